jk_register_bank: RTL and testbench

- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit bank of JK flip-flops sharing one clock.
- Four operating modes: per-bit JK, synchronous up-count, synchronous down-count and shift-left.
- Adds a clock enable, an asynchronous reset, a registered terminal-count flag and a registered change flag.
- Used as a general state/counter element in sequential datapaths.

---
 rtl/jk_register_bank_if.sv | 26 ++
 rtl/jk_register_bank.sv | 94 +++++++++
 tb/tb_jk_register_bank.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/jk_register_bank_if.sv
// Bus bundle for jk_register_bank: enable/mode/J/K toward the bank, Q/TC/CHG back.
// Latency: none here, this file only groups wires.
// Backpressure: none; the bank accepts a command on every enabled edge.
interface jk_register_bank_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             CHG;

  // Controller side: drives the command, observes state
  modport master (
    output EN, MODE, J, K,
    input  Q, TC, CHG
  );

  // Register bank side
  modport slave (
    input  EN, MODE, J, K,
    output Q, TC, CHG
  );
endinterface

// File: rtl/jk_register_bank.sv
// WIDTH-bit JK flip-flop bank: per-bit JK, count up, count down, shift left.
// Latency: one CLK edge from inputs to Q/TC/CHG; no combinational input->output path.
// Backpressure: none; EN=0 holds Q and TC and clears CHG. Macro JKREG_WRAP_EN selects wrap vs saturate.
module jk_register_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic               CLK,
  input logic               RST,
  jk_register_bank_if.slave bus
);

  localparam logic [1:0]       MODE_JK  = 2'b00;
  localparam logic [1:0]       MODE_UP  = 2'b01;
  localparam logic [1:0]       MODE_DN  = 2'b10;
  localparam logic [1:0]       MODE_SHL = 2'b11;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             chg_q, chg_d;

  logic [WIDTH-1:0] up_tgl;
  logic [WIDTH-1:0] dn_tgl;
  logic             q_all_ones;
  logic             q_all_zeros;
  logic [WIDTH:0]   shift_ext;
  logic [WIDTH-1:0] nxt;

  // Counter toggle masks: bit i toggles when every lower bit is 1 (up) or 0 (down)
  always_comb begin
    up_tgl      = '0;
    dn_tgl      = '0;
    q_all_ones  = 1'b1;
    q_all_zeros = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_tgl[i]   = q_all_ones;
      dn_tgl[i]   = q_all_zeros;
      q_all_ones  = q_all_ones & q_q[i];
      q_all_zeros = q_all_zeros & ~q_q[i];
    end
  end

  // Mode-dependent next state, all computed from the pre-edge Q
  always_comb begin
    // Appending J[0] below Q and dropping the top bit also covers WIDTH=1
    shift_ext = {q_q, bus.J[0]};
    nxt       = q_q;
    case (bus.MODE)
      MODE_JK:  nxt = (bus.J & ~q_q) | (~bus.K & q_q);
`ifdef JKREG_WRAP_EN
      MODE_UP:  nxt = q_q ^ up_tgl;
      MODE_DN:  nxt = q_q ^ dn_tgl;
`else
      MODE_UP:  nxt = q_all_ones  ? q_q : (q_q ^ up_tgl);
      MODE_DN:  nxt = q_all_zeros ? q_q : (q_q ^ dn_tgl);
`endif
      MODE_SHL: nxt = shift_ext[WIDTH-1:0];
      default:  nxt = q_q;
    endcase
  end

  // Enable gating and flag computation
  always_comb begin
    q_d   = q_q;
    tc_d  = tc_q;
    chg_d = 1'b0;
    if (bus.EN) begin
      q_d   = nxt;
      tc_d  = ((bus.MODE == MODE_UP) && (nxt == ALL_ONES)) ||
              ((bus.MODE == MODE_DN) && (nxt == ALL_ZERO));
      chg_d = (nxt != q_q);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q   <= RST_VAL;
      tc_q  <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      chg_q <= chg_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.TC  = tc_q;
  assign bus.CHG = chg_q;

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed bench for jk_register_bank (WIDTH=4) with an arithmetic reference model.
// Honours JKREG_WRAP_EN the same way the design does.
module tb_jk_register_bank;

  localparam int W = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  jk_register_bank_if #(.WIDTH(W)) ifc ();
  jk_register_bank_if #(.WIDTH(W)) ifc_b ();

  jk_register_bank #(.WIDTH(W), .RST_VAL(4'h0)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc.slave)
  );

  jk_register_bank #(.WIDTH(W), .RST_VAL(4'hA)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc_b.slave)
  );

  assign ifc_b.EN   = ifc.EN;
  assign ifc_b.MODE = ifc.MODE;
  assign ifc_b.J    = ifc.J;
  assign ifc_b.K    = ifc.K;

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the register value
  int m_q, m_tc, m_chg;
  always @(posedge CLK or posedge RST) begin
    int nq;
    if (RST) begin
      m_q = 0; m_tc = 0; m_chg = 0;
    end else if (!ifc.EN) begin
      m_chg = 0;
    end else begin
      nq = m_q;
      case (ifc.MODE)
        2'b00: begin
          for (int i = 0; i < W; i++) begin
            case ({ifc.J[i], ifc.K[i]})
              2'b01:   nq = nq & ~(1 << i);
              2'b10:   nq = nq | (1 << i);
              2'b11:   nq = nq ^ (1 << i);
              default: ;
            endcase
          end
        end
`ifdef JKREG_WRAP_EN
        2'b01: nq = (m_q + 1) % 16;
        2'b10: nq = (m_q + 15) % 16;
`else
        2'b01: nq = (m_q == 15) ? 15 : m_q + 1;
        2'b10: nq = (m_q == 0)  ? 0  : m_q - 1;
`endif
        default: nq = ((m_q * 2) + int'(ifc.J[0])) % 16;
      endcase
      m_tc  = ((ifc.MODE == 2'b01 && nq == 15) || (ifc.MODE == 2'b10 && nq == 0)) ? 1 : 0;
      m_chg = (nq != m_q) ? 1 : 0;
      m_q   = nq;
    end
  end

  // Compare DUT to model away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_q",   int'(ifc.Q),   m_q);
      chk("model_tc",  int'(ifc.TC),  m_tc);
      chk("model_chg", int'(ifc.CHG), m_chg);
    end
  end

  task automatic cyc(input logic en, input logic [1:0] mode, input logic [W-1:0] j,
                     input logic [W-1:0] k);
    @(negedge CLK);
    #1;
    ifc.EN = en; ifc.MODE = mode; ifc.J = j; ifc.K = k;
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    cyc(1'b1, 2'b00, v, ~v);
  endtask

  initial begin
    ifc.EN = 1'b0; ifc.MODE = 2'b00; ifc.J = '0; ifc.K = '0;
    #1 RST = 1'b1;
    #2;
    chk("rst_q",   int'(ifc.Q),   0);
    chk("rst_tc",  int'(ifc.TC),  0);
    chk("rst_chg", int'(ifc.CHG), 0);
    chk("rstval_a", int'(ifc_b.Q), 'hA);
    @(negedge CLK); #1 RST = 1'b0;
    chk_en = 1'b1;

    // Mid-cycle asynchronous reset with Q=1011
    load(4'b1011);
    chk("load_1011", int'(ifc.Q), 'hB);
    RST = 1'b1;
    #1;
    chk("async_rst_q",   int'(ifc.Q),   0);
    chk("async_rst_tc",  int'(ifc.TC),  0);
    chk("async_rst_chg", int'(ifc.CHG), 0);
    chk("async_rst_b",   int'(ifc_b.Q), 'hA);
    @(negedge CLK); #1 RST = 1'b0;

    // JK: Q=0101, J=1100, K=1010 -> toggle/set/clear/hold = 1101
    load(4'b0101);
    cyc(1'b1, 2'b00, 4'b1100, 4'b1010);
    chk("jk_q",   int'(ifc.Q),   'hD);
    chk("jk_chg", int'(ifc.CHG), 1);
    cyc(1'b1, 2'b00, 4'b0000, 4'b0000);
    chk("jk_hold_q",   int'(ifc.Q),   'hD);
    chk("jk_hold_chg", int'(ifc.CHG), 0);

    // Count up from D
    load(4'hD);
    cyc(1'b1, 2'b01, 4'hF, 4'hF);
    chk("up_e", int'(ifc.Q), 'hE);
    chk("up_e_tc", int'(ifc.TC), 0);
    cyc(1'b1, 2'b01, 4'h0, 4'h0);
    chk("up_f", int'(ifc.Q), 'hF);
    chk("up_f_tc", int'(ifc.TC), 1);
    cyc(1'b1, 2'b01, 4'h0, 4'h0);
`ifdef JKREG_WRAP_EN
    chk("up_wrap_q",   int'(ifc.Q),   0);
    chk("up_wrap_tc",  int'(ifc.TC),  0);
    chk("up_wrap_chg", int'(ifc.CHG), 1);
`else
    chk("up_sat_q",   int'(ifc.Q),   'hF);
    chk("up_sat_tc",  int'(ifc.TC),  1);
    chk("up_sat_chg", int'(ifc.CHG), 0);
`endif

    // Count down from 2
    load(4'h2);
    cyc(1'b1, 2'b10, 4'h0, 4'h0);
    chk("dn_1", int'(ifc.Q), 1);
    cyc(1'b1, 2'b10, 4'h0, 4'h0);
    chk("dn_0", int'(ifc.Q), 0);
    chk("dn_0_tc", int'(ifc.TC), 1);
    cyc(1'b1, 2'b10, 4'h0, 4'h0);
`ifdef JKREG_WRAP_EN
    chk("dn_wrap_q",  int'(ifc.Q),  'hF);
    chk("dn_wrap_tc", int'(ifc.TC), 0);
`else
    chk("dn_sat_q",   int'(ifc.Q),   0);
    chk("dn_sat_tc",  int'(ifc.TC),  1);
    chk("dn_sat_chg", int'(ifc.CHG), 0);
`endif

    // Shift 1,0,1,1 into zero
    load(4'h0);
    cyc(1'b1, 2'b11, 4'h1, 4'hF);
    cyc(1'b1, 2'b11, 4'hE, 4'hF);
    cyc(1'b1, 2'b11, 4'h1, 4'h0);
    cyc(1'b1, 2'b11, 4'h1, 4'h0);
    chk("shift_q",  int'(ifc.Q),  'hB);
    chk("shift_tc", int'(ifc.TC), 0);
    for (int n = 0; n < 3; n++) begin
      cyc(1'b0, 2'b01, 4'hF, 4'hF);
      chk("en0_q",   int'(ifc.Q),   'hB);
      chk("en0_chg", int'(ifc.CHG), 0);
    end

    // Mode switch with no idle cycle
    load(4'h1);
    cyc(1'b1, 2'b01, 4'h0, 4'h0);
    chk("sw_up2", int'(ifc.Q), 2);
    cyc(1'b1, 2'b01, 4'h0, 4'h0);
    chk("sw_up3", int'(ifc.Q), 3);
    cyc(1'b1, 2'b10, 4'h0, 4'h0);
    chk("sw_dn2", int'(ifc.Q), 2);
    chk("sw_dn2_chg", int'(ifc.CHG), 1);

    // TC holds through EN=0
    load(4'h1);
    cyc(1'b1, 2'b10, 4'h0, 4'h0);
    cyc(1'b0, 2'b00, 4'hF, 4'h0);
    chk("tc_hold_en0", int'(ifc.TC), 1);

    @(negedge CLK);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
